// File: rtl/aes_inv_cipher_top.sv
// AES-128 decryption core: buffered key schedule plus one inverse round per clock.
// Optional sticky protocol-error output `err` when compiled with AES_INV_ERR_EN.

module aes_gf_inv (
   input  logic [7:0] a_i,
   output logic [7:0] inv_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
      end
      return p;
   endfunction

   logic [7:0] r;

   // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
   always_comb begin
      r = a_i;
      for (int k = 0; k < 6; k++) begin
         r = gf_mul(gf_mul(r, r), a_i);
      end
      inv_o = gf_mul(r, r);
   end

endmodule

module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] b_o
);

   logic [7:0] s;

   aes_gf_inv u_inv (
      .a_i   (a_i),
      .inv_o (s)
   );

   assign b_o = s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]}
              ^ 8'h63;

endmodule

module aes_inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] b_o
);

   logic [7:0] t;

   // Undo the affine map first, then invert in the field.
   assign t = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;

   aes_gf_inv u_inv (
      .a_i   (t),
      .inv_o (b_o)
   );

endmodule

module aes_key_expand_128 (
   input  logic         clk_i,
   input  logic         kld_i,
   input  logic [127:0] key_i,
   output logic [31:0]  w0_o,
   output logic [31:0]  w1_o,
   output logic [31:0]  w2_o,
   output logic [31:0]  w3_o
);

   logic [31:0] w0_q, w1_q, w2_q, w3_q;
   logic [31:0] w0_d, w1_d, w2_d, w3_d;
   logic [31:0] sub_w;
   logic [7:0]  rcon_q, rcon_d;

   aes_sbox u_s0 (.a_i(w3_q[23:16]), .b_o(sub_w[31:24]));
   aes_sbox u_s1 (.a_i(w3_q[15:8]),  .b_o(sub_w[23:16]));
   aes_sbox u_s2 (.a_i(w3_q[7:0]),   .b_o(sub_w[15:8]));
   aes_sbox u_s3 (.a_i(w3_q[31:24]), .b_o(sub_w[7:0]));

   always_comb begin
      if (kld_i) begin
         w0_d   = key_i[127:96];
         w1_d   = key_i[95:64];
         w2_d   = key_i[63:32];
         w3_d   = key_i[31:0];
         rcon_d = 8'h01;
      end else begin
         w0_d   = w0_q ^ sub_w ^ {rcon_q, 24'h000000};
         w1_d   = w0_d ^ w1_q;
         w2_d   = w1_d ^ w2_q;
         w3_d   = w2_d ^ w3_q;
         rcon_d = {rcon_q[6:0], 1'b0} ^ (8'h1b & {8{rcon_q[7]}});
      end
   end

   always_ff @(posedge clk_i) begin
      w0_q   <= w0_d;
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      w3_q   <= w3_d;
      rcon_q <= rcon_d;
   end

   assign w0_o = w0_q;
   assign w1_o = w1_q;
   assign w2_o = w2_q;
   assign w3_o = w3_q;

endmodule

module aes_inv_cipher_top (
   input  logic         clk,
   input  logic         rst,
   input  logic         kld,
   input  logic [127:0] key,
   output logic         key_ready,
   input  logic         ld,
   input  logic [127:0] text_in,
   output logic         done,
`ifdef AES_INV_ERR_EN
   output logic         err,
`endif
   output logic [127:0] text_out
);

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
         o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
         o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
         o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
      end
      return o;
   endfunction

   logic [31:0]  w0, w1, w2, w3;
   logic [127:0] kb_q [11];
   logic [3:0]   kcnt_q, kcnt_d;
   logic [3:0]   dcnt_q, dcnt_d;
   logic         key_ready_q, key_ready_d;
   logic         done_q, done_d;
   logic         ld_r_q, ld_r_d;
   logic [127:0] text_in_r_q, text_in_r_d;
   logic [127:0] state_q, state_d;
   logic [127:0] text_out_q, text_out_d;
   logic [127:0] rk, isr, isb, ark, imc;
   logic         ld_acc;

   aes_key_expand_128 u_key_expand (
      .clk_i (clk),
      .kld_i (kld),
      .key_i (key),
      .w0_o  (w0),
      .w1_o  (w1),
      .w2_o  (w2),
      .w3_o  (w3)
   );

   assign ld_acc = ld & key_ready_q & ~kld;
   assign rk     = (dcnt_q != 4'd0) ? kb_q[dcnt_q - 4'd1] : '0;
   assign isr    = inv_shift_rows(state_q);

   for (genvar i = 0; i < 16; i++) begin : g_isb
      aes_inv_sbox u_isb (
         .a_i (isr[127-8*i -: 8]),
         .b_o (isb[127-8*i -: 8])
      );
   end

   assign ark = isb ^ rk;
   assign imc = inv_mix_columns(ark);

   // Control: kld overrides everything, then an accepted ld, then round progress.
   always_comb begin
      kcnt_d      = kcnt_q;
      key_ready_d = key_ready_q;
      dcnt_d      = dcnt_q;
      ld_r_d      = 1'b0;
      done_d      = 1'b0;
      text_out_d  = text_out_q;
      if (kcnt_q != 4'd0) kcnt_d = kcnt_q - 4'd1;
      if (kcnt_q == 4'd1) key_ready_d = 1'b1;
      if (dcnt_q != 4'd0) dcnt_d = dcnt_q - 4'd1;
      if (kld) begin
         kcnt_d      = 4'd11;
         key_ready_d = 1'b0;
         dcnt_d      = 4'd0;
      end else if (ld_acc) begin
         dcnt_d = 4'd11;
         ld_r_d = 1'b1;
      end else if (dcnt_q == 4'd1) begin
         text_out_d = ark;
         done_d     = 1'b1;
      end
   end

   always_comb begin
      text_in_r_d = ld_acc ? text_in : text_in_r_q;
      if (ld_r_q) begin
         state_d = text_in_r_q ^ rk;
      end else if (dcnt_q > 4'd1) begin
         state_d = imc;
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         kcnt_q      <= 4'd0;
         dcnt_q      <= 4'd0;
         key_ready_q <= 1'b0;
         done_q      <= 1'b0;
         ld_r_q      <= 1'b0;
         text_out_q  <= '0;
      end else begin
         kcnt_q      <= kcnt_d;
         dcnt_q      <= dcnt_d;
         key_ready_q <= key_ready_d;
         done_q      <= done_d;
         ld_r_q      <= ld_r_d;
         text_out_q  <= text_out_d;
      end
   end

   // Round key r is on w0..w3 one edge before it is written to kb[r].
   always_ff @(posedge clk) begin
      if (kcnt_q != 4'd0) kb_q[4'd11 - kcnt_q] <= {w0, w1, w2, w3};
      text_in_r_q <= text_in_r_d;
      state_q     <= state_d;
   end

   assign key_ready = key_ready_q;
   assign done      = done_q;
   assign text_out  = text_out_q;

`ifdef AES_INV_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (kld) err_d = 1'b0;
      if (ld && (!key_ready_q || kld || dcnt_q != 4'd0)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule
